// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the load/store unit: funct3 codes, memory size
// controls, FSM encoding and the request legality check.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [2:0] BYTE = 3'b000;
  localparam logic [2:0] HALF = 3'b001;
  localparam logic [2:0] WORD = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } lsu_state_e;

  // True when the request must be answered with a fault instead of a memory access.
  function automatic logic lsu_fault(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (we) begin
      illegal = !(funct3 inside {SB, SH, SW});
    end else begin
      illegal = !(funct3 inside {LB, LH, LW, LBU, LHU});
    end
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// master: the requester plus memory side; slave: the load/store unit itself.
interface load_store_unit_if #(
  parameter int unsigned WORD_SIZE = 32
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [WORD_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_wdata;

  logic                 rsp_valid;
  logic [WORD_SIZE-1:0] rsp_rdata;
  logic                 rsp_fault;

  logic [WORD_SIZE-1:0] mem_addr;
  logic                 mem_write_en;
  logic [WORD_SIZE-1:0] mem_write_data;
  logic [2:0]           mem_ctrl;
  logic [WORD_SIZE-1:0] mem_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_addr, mem_write_en, mem_write_data, mem_ctrl
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_addr, mem_write_en, mem_write_data, mem_ctrl
  );

endinterface

// File: rtl/load_extend.sv
// Combinational load-data extension: selects the accessed bytes from the memory word
// and sign- or zero-extends them according to funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_data,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = '0;
    case (funct3)
      LB:      ext_data = {{24{mem_data[7]}}, mem_data[7:0]};
      LH:      ext_data = {{16{mem_data[15]}}, mem_data[15:0]};
      LW:      ext_data = mem_data;
      LBU:     ext_data = {24'h0, mem_data[7:0]};
      LHU:     ext_data = {16'h0, mem_data[15:0]};
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, performs a single memory access cycle and
// returns a one-cycle response. Illegal or misaligned requests skip the access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  lsu_state_e           state_q, state_d;
  logic [2:0]           funct3_q, funct3_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 fault_q, fault_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]           mem_ctrl_q, mem_ctrl_d;

  logic                 accept;
  logic                 req_fault;
  logic [31:0]          ext_data;

  assign accept    = bus.req_valid & bus.req_ready;
  assign req_fault = lsu_fault(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  load_extend u_load_extend (
    .funct3   (funct3_q),
    .mem_data (bus.mem_data),
    .ext_data (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_ctrl_d  = mem_ctrl_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          funct3_d = bus.req_funct3;
          we_d     = bus.req_we;
          rdata_d  = '0;
          fault_d  = req_fault;
          if (req_fault) begin
            state_d = StResp;
          end else begin
            // Memory-side registers only move for real accesses, so they hold across faults.
            state_d     = StAccess;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata;
            mem_ctrl_d  = {1'b0, bus.req_funct3[1:0]};
          end
        end
      end
      StAccess: begin
        if (!we_q) begin
          rdata_d = ext_data;
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ctrl_q  <= '0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_ctrl_q  <= mem_ctrl_d;
    end
  end

  assign bus.req_ready      = (state_q == StIdle) & rst;
  assign bus.rsp_valid      = (state_q == StResp);
  assign bus.rsp_rdata      = rdata_q;
  assign bus.rsp_fault      = fault_q;
  // Gated by rst combinationally so a reset during ACCESS kills the write at that edge.
  assign bus.mem_write_en   = (state_q == StAccess) & we_q & rst;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.mem_ctrl       = mem_ctrl_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-addressed memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.WORD_SIZE(32)) bus ();

  load_store_unit #(.WORD_SIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: 256 bytes, little-endian, asynchronous read, write at the clock edge.
  logic [7:0] mem [256];
  logic [7:0] ma;
  assign ma = bus.mem_addr[7:0];
  assign bus.mem_data = {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)], mem[8'(ma + 8'd1)], mem[ma]};

  always @(posedge clk) begin
    if (bus.mem_write_en) begin
      mem[ma] <= bus.mem_write_data[7:0];
      if (bus.mem_ctrl != BYTE) mem[8'(ma + 8'd1)] <= bus.mem_write_data[15:8];
      if (bus.mem_ctrl == WORD) begin
        mem[8'(ma + 8'd2)] <= bus.mem_write_data[23:16];
        mem[8'(ma + 8'd3)] <= bus.mem_write_data[31:24];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after the response.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic fault, output int lat, output int we_n,
                       output logic [2:0] ctrl_at_we);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    we_n = 0;
    rdata = 32'hx;
    fault = 1'bx;
    ctrl_at_we = 3'b111;
    for (int i = 1; i <= 4; i++) begin
      if (bus.mem_write_en) begin
        we_n++;
        ctrl_at_we = bus.mem_ctrl;
      end
      if (bus.rsp_valid) begin
        lat = i;
        rdata = bus.rsp_rdata;
        fault = bus.rsp_fault;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        flt;
  int          lat;
  int          we_n;
  logic [2:0]  ctl;
  logic [8:0]  rdy_pat;
  logic [8:0]  rsp_pat;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mem_wdata", bus.mem_write_data, 32'h0);
    check_eq("rst_mem_ctrl", 32'(bus.mem_ctrl), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_write_en), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // Store then load
    issue(1'b1, SW, 32'h80, 32'hDEADBEEF, rd, flt, lat, we_n, ctl);
    check_eq("sw_lat", 32'(lat), 32'd2);
    check_eq("sw_we_cycles", 32'(we_n), 32'd1);
    check_eq("sw_ctrl", 32'(ctl), 32'(WORD));
    check_eq("sw_fault", 32'(flt), 32'd0);
    check_eq("sw_rdata", rd, 32'h0);
    issue(1'b0, LW, 32'h80, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("lw_rdata", rd, 32'hDEADBEEF);
    check_eq("lw_lat", 32'(lat), 32'd2);
    check_eq("lw_fault", 32'(flt), 32'd0);
    check_eq("lw_we_cycles", 32'(we_n), 32'd0);

    // Extension
    issue(1'b1, SW, 32'h84, 32'h000080F0, rd, flt, lat, we_n, ctl);
    issue(1'b0, LB, 32'h84, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("lb", rd, 32'hFFFFFFF0);
    issue(1'b0, LBU, 32'h84, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("lbu", rd, 32'h000000F0);
    issue(1'b0, LH, 32'h84, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("lh", rd, 32'hFFFF80F0);
    issue(1'b0, LHU, 32'h84, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("lhu", rd, 32'h000080F0);
    issue(1'b0, LB, 32'h85, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("lb_odd", rd, 32'hFFFFFF80);
    issue(1'b0, LBU, 32'h85, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("lbu_odd", rd, 32'h00000080);

    // Byte store only touches one byte
    issue(1'b1, SB, 32'h86, 32'hAABBCC55, rd, flt, lat, we_n, ctl);
    check_eq("sb_ctrl", 32'(ctl), 32'(BYTE));
    issue(1'b0, LW, 32'h84, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("sb_readback", rd, 32'h005580F0);

    // Faults
    issue(1'b0, LW, 32'h82, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("lw_mis_fault", 32'(flt), 32'd1);
    check_eq("lw_mis_rdata", rd, 32'h0);
    check_eq("lw_mis_lat", 32'(lat), 32'd1);
    issue(1'b1, SH, 32'h85, 32'h00001111, rd, flt, lat, we_n, ctl);
    check_eq("sh_mis_fault", 32'(flt), 32'd1);
    check_eq("sh_mis_we", 32'(we_n), 32'd0);
    check_eq("sh_mis_lat", 32'(lat), 32'd1);
    issue(1'b0, 3'b011, 32'h80, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("ld011_fault", 32'(flt), 32'd1);
    check_eq("ld011_rdata", rd, 32'h0);
    check_eq("ld011_lat", 32'(lat), 32'd1);
    issue(1'b1, 3'b100, 32'h80, 32'h22222222, rd, flt, lat, we_n, ctl);
    check_eq("st100_fault", 32'(flt), 32'd1);
    check_eq("st100_we", 32'(we_n), 32'd0);
    check_eq("st100_lat", 32'(lat), 32'd1);
    check_eq("hold_mem_addr", bus.mem_addr, 32'h84);
    check_eq("hold_mem_ctrl", 32'(bus.mem_ctrl), 32'(WORD));
    issue(1'b0, LW, 32'h84, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("after_faults_mem", rd, 32'h005580F0);
    issue(1'b0, LW, 32'h80, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("after_faults_mem80", rd, 32'hDEADBEEF);

    // Handshake hold: valid stays high for nine cycles
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = LW;
    bus.req_addr   = 32'h80;
    for (int i = 8; i >= 0; i--) begin
      rdy_pat[i] = bus.req_ready;
      rsp_pat[i] = bus.rsp_valid;
      if (i == 0) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    check_eq("hold_ready_pattern", 32'(rdy_pat), 32'b100100100);
    check_eq("hold_rsp_pattern", 32'(rsp_pat), 32'b001001001);

    // Reset during the ACCESS cycle of a store
    issue(1'b1, SW, 32'h90, 32'hCAFEF00D, rd, flt, lat, we_n, ctl);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = SW;
    bus.req_addr   = 32'h90;
    bus.req_wdata  = 32'h12345678;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("pre_rst_we", 32'(bus.mem_write_en), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rst_kills_we", 32'(bus.mem_write_en), 32'd0);
    @(negedge clk);
    check_eq("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("mid_rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("mid_rst_mem_wdata", bus.mem_write_data, 32'h0);
    check_eq("mid_rst_mem_ctrl", 32'(bus.mem_ctrl), 32'd0);
    check_eq("mid_rst_rdata", bus.rsp_rdata, 32'h0);
    check_eq("mid_rst_fault", 32'(bus.rsp_fault), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("post_rst_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b0, LW, 32'h90, 32'h0, rd, flt, lat, we_n, ctl);
    check_eq("old_contents", rd, 32'hCAFEF00D);
    check_eq("old_contents_lat", 32'(lat), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequences every data-memory access between the CPU datapath and the byte-addressable combined memory. It accepts one load or store request through a valid/ready handshake and checks alignment and funct3 legality. It drives the memory's write-enable/address/ctrl port for exactly one access cycle. Load data is sign- or zero-extended and returned as a single-cycle response pulse.

## Interface
- WORD_SIZE, 32, datapath and memory word width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (IDLE and rst high).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  WORD_SIZE  byte address.
- req_wdata  in  WORD_SIZE  store data, low bytes significant.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  WORD_SIZE  extended load data; 0 for stores and faults.
- rsp_fault  out  1  misaligned or illegal funct3; valid with rsp_valid.
- mem_addr  out  WORD_SIZE  memory address (registered request address).
- mem_write_en  out  1  memory write strobe.
- mem_write_data  out  WORD_SIZE  registered req_wdata.
- mem_ctrl  out  3  memory size control: 000 byte, 001 half, 010 word.
- mem_data  in  WORD_SIZE  asynchronous memory read data, little-endian, byte at mem_addr in [7:0].

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, register addr, funct3, we and wdata. Next state is RESP with fault=1 if the request is illegal, otherwise ACCESS.
- Legal loads: funct3 is 000 LB, 001 LH, 010 LW, 100 LBU or 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Every other code is a fault.
- Misaligned: half-word access with addr[0]=1; word access with addr[1:0]≠00. This is a fault.
- A fault never asserts mem_write_en and never samples mem_data.
- ACCESS: mem_ctrl = {1'b0, funct3[1:0]}.
  - Store: mem_write_en=1 for this cycle only. The memory writes at the closing edge.
  - Load: mem_data is sampled at the closing edge and extended into the rdata register.
  - Next state is always RESP.
- Extension rules:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
  - Bytes above the access size in mem_data are ignored.
- RESP: rsp_valid=1 and rsp_rdata/rsp_fault are driven from registers. Next state is IDLE.
- mem_addr/mem_write_data/mem_ctrl hold their last values outside ACCESS.

## Timing
- Handshake at edge N (req_valid & req_ready). ACCESS occupies cycle N→N+1. rsp_valid is high in cycle N+1→N+2.
- Fault path skips ACCESS, so rsp_valid is high in cycle N→N+1.
- Throughput: one request per 3 cycles, or per 2 cycles on faults. req_valid while req_ready=0 is ignored and must be held by the requester.
- mem_write_en = (state==ACCESS) & we & rst. This is combinational so that a reset asserted during ACCESS suppresses the write at the same edge.
- Reset (rst low at an edge) puts the FSM in IDLE and clears all registers. Output values while rst is low and after reset:
  - rsp_valid=0, rsp_rdata=0, rsp_fault=0
  - mem_addr=0, mem_write_data=0, mem_ctrl=000, mem_write_en=0
  - req_ready=0 while rst is low, then 1 in the first cycle after release
- Reset mid-operation drops the in-flight request with no response. The requester re-issues it.
- Back-to-back: a new request may be accepted in the cycle after RESP, i.e. the first IDLE cycle.

## Structure
- Package lsu_pkg:
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW.
  - memory ctrl constants BYTE/HALF/WORD (000/001/010).
  - FSM state encoding.
- Sub-module load_extend: combinational; funct3 + mem_data in, extended 32-bit word out. Instantiated once and feeding the rdata register.

## Test plan
- Store then load (SW 0xDEADBEEF @0x80, then LW @0x80):
  - mem_write_en high exactly one cycle with mem_ctrl=010.
  - Load returns 0xDEADBEEF, rsp_valid 2 cycles after the handshake, rsp_fault=0.
- Sign/zero extension, memory word @0x84 = 0x0000_80F0:
  - LB @0x84 → 0xFFFFFFF0; LBU → 0x000000F0.
  - LH → 0xFFFF80F0; LHU → 0x000080F0.
- Misaligned/illegal requests, each → rsp_fault=1, rsp_rdata=0, mem_write_en never high, response 1 cycle after the handshake:
  - LW @0x82
  - SH @0x85
  - load with funct3=011
  - store with funct3=100
- Handshake hold: req_valid held high continuously.
  - Requests accepted only at 3-cycle intervals.
  - req_ready low during ACCESS/RESP.
  - Exactly one rsp_valid pulse per accept.
- Reset mid-store: rst low during the ACCESS cycle of SW 0x12345678 @0x90.
  - mem_write_en stays 0 and no rsp_valid is produced.
  - All outputs are at their reset values the next cycle.
  - A following LW @0x90 returns the old contents.
